// File: rtl/shift_right_serial_64_pkg.sv
// Shared definitions for the serial 64-bit right shifter: operand/amount
// widths, the control FSM encoding and the fill-bit helper used by the
// single-step shifter.
package shift_right_serial_64_pkg;

    // Operand width (only 64 is supported) and shift-amount width log2(WIDTH).
    localparam int unsigned WIDTH_DEF = 64;
    localparam int unsigned SHW_DEF   = 6;

    // Control FSM encoding. ST_ILLEGAL is never entered on purpose; if it is
    // ever reached (e.g. an upset), the FSM falls back to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_DONE    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

    // Bit shifted in at the MSB: copy of the sign for arithmetic shifts,
    // zero for logical shifts.
    function automatic logic shift_fill(input logic arith, input logic msb);
        return arith & msb;
    endfunction

endpackage

// File: rtl/shift_right_serial_64_one.sv
// Combinational single-step right shifter: data_o = {fill, data_i[W-1:1]}.
// Sits on the next-state path of the serial shifter's data register and is
// the right-shift counterpart of the shift-left-by-one offset block.
module shift_right_serial_64_one
    import shift_right_serial_64_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             arith_i,
    output logic [WIDTH-1:0] data_o
);

    logic fill_s;
    logic unused_lsb_s;

    // Shift one place right, inserting the fill bit and dropping bit 0.
    always_comb begin
        fill_s       = shift_fill(arith_i, data_i[WIDTH-1]);
        data_o       = {fill_s, data_i[WIDTH-1:1]};
        unused_lsb_s = data_i[0];
    end

endmodule

// File: rtl/shift_right_serial_64.sv
// Multi-cycle 64-bit right shifter (logical or arithmetic). A request is
// accepted in IDLE, shifted one bit per clock in SHIFT while a down-counter
// runs out, then held in DONE until the consumer takes it. One request is in
// flight at a time; all outputs come straight from registers.
module shift_right_serial_64
    import shift_right_serial_64_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned SHW   = SHW_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic             arith_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] data_o
);

    localparam logic [SHW-1:0] CNT_ZERO = {SHW{1'b0}};
    localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

    state_e           state_r;
    state_e           next_state_s;
    logic             accept_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_step_s;
    logic [SHW-1:0]   cnt_r;
    logic             arith_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             in_ready_nxt_s;
    logic             out_valid_nxt_s;

    // A request is taken only while idle; in_valid_i is ignored elsewhere.
    assign accept_s = in_valid_i & (state_r == ST_IDLE);

    // One-bit step of the held operand, fed back into the data register.
    shift_right_serial_64_one #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_i  (shreg_r),
        .arith_i (arith_r),
        .data_o  (shreg_step_s)
    );

    // Next-state logic for the IDLE -> SHIFT -> DONE -> IDLE sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (shamt_i == CNT_ZERO) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_SHIFT;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // The step taken while cnt is 1 is the last one. cnt is never
                // 0 here, but treat it as finished rather than wrap around.
                if (cnt_r <= CNT_ONE) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Handshake flags decoded from the upcoming state so they can be
    // registered alongside it.
    always_comb begin
        in_ready_nxt_s  = 1'b0;
        out_valid_nxt_s = 1'b0;
        case (next_state_s)
            ST_IDLE: begin
                in_ready_nxt_s  = 1'b1;
                out_valid_nxt_s = 1'b0;
            end
            ST_SHIFT: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b0;
            end
            ST_DONE: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b1;
            end
            default: begin
                in_ready_nxt_s  = 1'b0;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State register plus registered handshake outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= in_ready_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    // Datapath: capture the request on accept, step and count down while
    // shifting, and hold the result steady while it waits in DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            arith_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        shreg_r <= data_i;
                        cnt_r   <= shamt_i;
                        arith_r <= arith_i;
                    end else begin
                        shreg_r <= shreg_r;
                        cnt_r   <= cnt_r;
                        arith_r <= arith_r;
                    end
                end
                ST_SHIFT: begin
                    shreg_r <= shreg_step_s;
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_DONE: begin
                    shreg_r <= shreg_r;
                    cnt_r   <= cnt_r;
                end
                default: begin
                    shreg_r <= shreg_r;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign data_o      = shreg_r;

endmodule

// File: tb/tb_shift_right_serial_64.sv
// Scoreboard bench for shift_right_serial_64: stimulus pushes the expected
// result and accept cycle into a queue; an independent monitor pops and
// checks result data, latency and stability whenever the DUT presents one.
module tb_shift_right_serial_64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] data_in;
    logic [5:0]  shamt;
    logic        arith;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] data_out;

    typedef struct {
        logic [63:0] data;
        int          shamt;
        longint      acc_cyc;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     ready_mode = 0;   // 0: always ready, 1: random, 2: never ready

    shift_right_serial_64 dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .data_i      (data_in),
        .shamt_i     (shamt),
        .arith_i     (arith),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain >> / >>> of the operand.
    function automatic logic [63:0] ref_shift(input logic [63:0] d, input int n, input logic a);
        logic signed [63:0] sd;
        sd = d;
        if (a) return sd >>> n;
        return d >> n;
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present a request until accepted, then scramble the inputs.
    task automatic send(input logic [63:0] d, input int n, input logic a, input logic [63:0] exp_d);
        bit accepted;
        exp_t e;
        accepted = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        data_in  = d;
        shamt    = 6'(n);
        arith    = a;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.data    = exp_d;
                e.shamt   = n;
                e.acc_cyc = cyc;
                q.push_back(e);
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) check_int("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in  = {$urandom, $urandom};
        shamt    = 6'($urandom);
        arith    = 1'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) return;
        end
        check_int("drain_timeout", q.size(), 0);
    endtask

    // Back-pressure driver for out_ready.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: checks each presented result against the queue head.
    initial begin
        bit prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else if (out_valid) begin
                check_int("in_ready_while_valid", in_ready, 0);
                if (q.size() == 0) begin
                    if (!prev_valid) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got %h expected none (cycle %0d)", data_out, cyc);
                    end
                end else begin
                    if (!prev_valid)
                        check_int("latency", cyc - q[0].acc_cyc, q[0].shamt + 1);
                    check64("result", data_out, q[0].data);
                end
                if (out_ready) begin
                    if (q.size() > 0) void'(q.pop_front());
                    prev_valid = 1'b0;
                end else begin
                    prev_valid = 1'b1;
                end
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    // Global time limit.
    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    // Stimulus.
    initial begin
        logic [63:0] d;
        int          n;
        logic        a;
        int          seen;

        rst = 1'b1; in_valid = 1'b0; data_in = 64'd0; shamt = 6'd0; arith = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_int("reset_in_ready", in_ready, 1);
        check_int("reset_out_valid", out_valid, 0);
        check64("reset_data", data_out, 64'd0);

        // Directed values.
        ready_mode = 0;
        send(64'hF000_0000_0000_0001, 4, 1'b0, 64'h0F00_0000_0000_0000);
        wait_idle(200);
        send(64'h8000_0000_0000_0000, 63, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_idle(200);
        send(64'h8000_0000_0000_0000, 63, 1'b0, 64'h0000_0000_0000_0001);
        wait_idle(200);
        send(64'hF000_0000_0000_0001, 4, 1'b1, 64'hFF00_0000_0000_0000);
        wait_idle(200);

        // Zero shift, then hold the result under back-pressure.
        ready_mode = 2;
        send(64'h1234_5678_9ABC_DEF0, 0, 1'b1, 64'h1234_5678_9ABC_DEF0);
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            if (out_valid) seen = 1; else @(negedge clk);
        end
        check_int("zero_shift_valid", seen, 1);
        repeat (5) begin
            @(negedge clk);
            check_int("hold_valid", out_valid, 1);
            check_int("hold_in_ready", in_ready, 0);
            check64("hold_data", data_out, 64'h1234_5678_9ABC_DEF0);
        end
        ready_mode = 0;
        wait_idle(50);

        // New request during SHIFT is ignored; next one waits for handshake.
        send(64'hDEAD_BEEF_0123_4567, 20, 1'b1, 64'hFFFF_FDEA_DBEE_F012);
        @(posedge clk); #1;
        in_valid = 1'b1; data_in = 64'hFFFF_FFFF_FFFF_FFFF; shamt = 6'd1; arith = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_int("busy_in_ready", in_ready, 0);
        end
        send(64'h0000_0000_0000_FF00, 8, 1'b0, 64'h0000_0000_0000_00FF);
        wait_idle(200);

        // Reset in the middle of a 10-bit shift.
        send(64'hFFFF_0000_FFFF_0000, 10, 1'b1, ref_shift(64'hFFFF_0000_FFFF_0000, 10, 1'b1));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_int("abort_in_ready", in_ready, 1);
        check_int("abort_out_valid", out_valid, 0);
        check64("abort_data", data_out, 64'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check_int("no_stale_result", seen, 0);

        // Random operands, amounts and modes under random back-pressure.
        ready_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            d = {$urandom, $urandom};
            n = $urandom_range(63);
            a = 1'($urandom_range(1));
            send(d, n, a, ref_shift(d, n, a));
        end
        ready_mode = 0;
        wait_idle(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
